// File: rtl/dot_product_engine.sv
// dot_product_engine
// Serial dot-product unit: one A/B vector pair per transaction, one
// multiply-accumulate per cycle, full-precision result with optional
// two's-complement elements and accumulation chaining across transactions.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. The input port is ready only in IDLE;
// the output port is valid only in DONE, and result is stable for as long as
// out_valid stays high. Neither port overlaps with the other: a new vector
// pair can be taken only after the previous result has been consumed.

module dot_product_engine #(
  parameter int NBITS   = 4,
  parameter int NDATA   = 3,
  parameter int SIGNED  = 0,
  parameter int ACCBITS = 2*NBITS + $clog2(NDATA+1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NDATA*NBITS-1:0] A,
  input  logic [NDATA*NBITS-1:0] B,
  input  logic                   chain,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACCBITS-1:0]     result,
  output logic                   busy,
  output logic [1:0]             fsm_state
);

  // Index width must stay at least one bit even when NDATA=1.
  localparam int IDXW = (NDATA > 1) ? $clog2(NDATA) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDATA-1);
  localparam int VECW = NDATA*NBITS;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [VECW-1:0]    a_sh;
  logic [VECW-1:0]    b_sh;
  logic [IDXW-1:0]    idx;
  logic [ACCBITS-1:0] acc;

  logic [ACCBITS-1:0] a_ext;
  logic [ACCBITS-1:0] b_ext;
  logic [ACCBITS-1:0] prod;

  logic accept;
  logic release_out;
  logic last_mac;

  assign accept      = in_valid && (state == ST_IDLE);
  assign release_out = out_ready && (state == ST_DONE);
  assign last_mac    = (state == ST_RUN) && (idx == LAST_IDX);

  // State register: synchronous reset returns to IDLE and aborts any work.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE -> RUN on accept, RUN -> DONE after the last
  // element, DONE -> IDLE once the consumer takes the result.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (accept)      state_next = ST_RUN;
      ST_RUN:  if (last_mac)    state_next = ST_DONE;
      ST_DONE: if (release_out) state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  // Output decode: handshake flags and status come straight from the state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ST_IDLE: in_ready  = 1'b1;
      ST_RUN:  busy      = 1'b1;
      ST_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready  = 1'b0;
    endcase
  end

  assign fsm_state = state;

  // Element extension to accumulator width. With the guard bits in ACCBITS
  // the ACCBITS-wide product of two extended elements is exact, and the
  // modulo-2^ACCBITS multiply yields the correct two's-complement product.
  always_comb begin
    a_ext = {{(ACCBITS-NBITS){1'b0}}, a_sh[NBITS-1:0]};
    b_ext = {{(ACCBITS-NBITS){1'b0}}, b_sh[NBITS-1:0]};
    if (SIGNED != 0) begin
      a_ext = {{(ACCBITS-NBITS){a_sh[NBITS-1]}}, a_sh[NBITS-1:0]};
      b_ext = {{(ACCBITS-NBITS){b_sh[NBITS-1]}}, b_sh[NBITS-1:0]};
    end
  end

  assign prod = a_ext * b_ext;

  // Datapath: capture operands on accept, then one MAC per RUN cycle with
  // both shifters stepping one element toward the LSBs. acc is left alone in
  // DONE and IDLE so the result holds under backpressure and afterwards.
  // A chained accept keeps acc; wrap-around on long chains is modulo 2^ACCBITS.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sh <= '0;
      b_sh <= '0;
      idx  <= '0;
      acc  <= '0;
    end else begin
      if (accept) begin
        a_sh <= A;
        b_sh <= B;
        idx  <= '0;
        if (!chain) begin
          acc <= '0;
        end
      end else if (state == ST_RUN) begin
        acc  <= acc + prod;
        a_sh <= a_sh >> NBITS;
        b_sh <= b_sh >> NBITS;
        idx  <= idx + 1'b1;
      end
    end
  end

  assign result = acc;

endmodule

// File: tb/tb_dot_product_engine.sv
// tb_dot_product_engine
// Directed bench for dot_product_engine at NBITS=4, NDATA=3. An unsigned and
// a signed instance share every input, so each transaction is checked
// against both hand-computed results.

module tb_dot_product_engine;

  localparam int NBITS   = 4;
  localparam int NDATA   = 3;
  localparam int ACCBITS = 10;
  localparam int VECW    = NBITS*NDATA;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic            in_valid;
  logic [VECW-1:0] a_vec;
  logic [VECW-1:0] b_vec;
  logic            chain;
  logic            out_ready;

  logic               in_ready_u,  in_ready_s;
  logic               out_valid_u, out_valid_s;
  logic               busy_u,      busy_s;
  logic [ACCBITS-1:0] result_u,    result_s;
  logic [1:0]         fsm_u,       fsm_s;

  int errors = 0;
  int checks = 0;

  dot_product_engine #(.NBITS(NBITS), .NDATA(NDATA), .SIGNED(0)) dut_u (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_u),
    .A(a_vec), .B(b_vec), .chain(chain), .out_valid(out_valid_u),
    .out_ready(out_ready), .result(result_u), .busy(busy_u), .fsm_state(fsm_u)
  );

  dot_product_engine #(.NBITS(NBITS), .NDATA(NDATA), .SIGNED(1)) dut_s (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_s),
    .A(a_vec), .B(b_vec), .chain(chain), .out_valid(out_valid_s),
    .out_ready(out_ready), .result(result_s), .busy(busy_s), .fsm_state(fsm_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Both engines idle with the given held result.
  task automatic check_idle(input string tag, input logic [31:0] exp_u, input logic [31:0] exp_s);
    check({tag, "_in_ready_u"},  {31'd0, in_ready_u},  32'd1);
    check({tag, "_in_ready_s"},  {31'd0, in_ready_s},  32'd1);
    check({tag, "_out_valid_u"}, {31'd0, out_valid_u}, 32'd0);
    check({tag, "_busy_u"},      {31'd0, busy_u},      32'd0);
    check({tag, "_state_u"},     {30'd0, fsm_u},       32'd0);
    check({tag, "_result_u"},    {22'd0, result_u},    exp_u);
    check({tag, "_result_s"},    {22'd0, result_s},    exp_s);
  endtask

  // Offer one vector pair, measure accept-to-out_valid latency, check both
  // results. Leaves both engines in DONE; consume_result releases them.
  task automatic send_and_wait(input string tag, input logic [VECW-1:0] a, input logic [VECW-1:0] b,
                               input logic ch, input logic [31:0] exp_u, input logic [31:0] exp_s);
    int cycles;
    a_vec    = a;
    b_vec    = b;
    chain    = ch;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chain    = 1'b0;
    check({tag, "_busy_after_accept"}, {31'd0, busy_u}, 32'd1);
    cycles = 0;
    while (!out_valid_u && cycles < 20) begin
      step();
      cycles++;
    end
    check({tag, "_latency"},     cycles,               NDATA);
    check({tag, "_out_valid_s"}, {31'd0, out_valid_s}, 32'd1);
    check({tag, "_result_u"},    {22'd0, result_u},    exp_u);
    check({tag, "_result_s"},    {22'd0, result_s},    exp_s);
  endtask

  task automatic consume_result(input string tag, input logic [31:0] exp_u, input logic [31:0] exp_s);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check_idle({tag, "_after_take"}, exp_u, exp_s);
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    a_vec     = '0;
    b_vec     = '0;
    chain     = 1'b0;
    out_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    check_idle("reset", 32'd0, 32'd0);

    // 1: A={3,2,1}, B={6,5,4}: 1*4+2*5+3*6 = 32 in both modes
    send_and_wait("basic", 12'h321, 12'h654, 1'b0, 32'd32, 32'd32);
    consume_result("basic", 32'd32, 32'd32);

    // 2: all 15: unsigned 3*225 = 675; signed (-1)*(-1)*3 = 3
    send_and_wait("max", 12'hFFF, 12'hFFF, 1'b0, 32'd675, 32'd3);
    consume_result("max", 32'd675, 32'd3);

    // 3a: A all 4'hF, B all 2: unsigned 90; signed -6 = 10'h3FA
    send_and_wait("neg", 12'hFFF, 12'h222, 1'b0, 32'd90, 32'h3FA);
    consume_result("neg", 32'd90, 32'h3FA);

    // 3b: all -8 (4'h8): 64*3 = 192 in both modes
    send_and_wait("min", 12'h888, 12'h888, 1'b0, 32'd192, 32'd192);
    consume_result("min", 32'd192, 32'd192);

    // 4: backpressure for 5 cycles with a competing in_valid
    send_and_wait("bp", 12'h321, 12'h654, 1'b0, 32'd32, 32'd32);
    a_vec    = 12'hFFF;
    b_vec    = 12'hFFF;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_out_valid", {31'd0, out_valid_u}, 32'd1);
      check("bp_hold_in_ready",  {31'd0, in_ready_u},  32'd0);
      check("bp_hold_result_u",  {22'd0, result_u},    32'd32);
      check("bp_hold_result_s",  {22'd0, result_s},    32'd32);
    end
    in_valid = 1'b0;
    consume_result("bp", 32'd32, 32'd32);
    step();
    check_idle("bp_idle_hold", 32'd32, 32'd32);

    // 5: chain onto previous 32 -> 64, then a cleared run -> 32
    send_and_wait("chain", 12'h321, 12'h654, 1'b1, 32'd64, 32'd64);
    consume_result("chain", 32'd64, 32'd64);
    send_and_wait("unchain", 12'h321, 12'h654, 1'b0, 32'd32, 32'd32);
    consume_result("unchain", 32'd32, 32'd32);

    // 6: reset during the second RUN cycle aborts the transaction
    a_vec    = 12'h888;
    b_vec    = 12'h888;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    check("rst_mid_run_busy", {31'd0, busy_u}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_idle("rst_mid_run", 32'd0, 32'd0);
    step();
    check("rst_no_resume", {31'd0, out_valid_u}, 32'd0);
    send_and_wait("after_rst", 12'hFFF, 12'h222, 1'b0, 32'd90, 32'h3FA);
    consume_result("after_rst", 32'd90, 32'h3FA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
